// File: rtl/mac_cfg_ctrl.sv
// rtl/mac_cfg_ctrl.sv - push-button command sequencer and source-MAC commit control
module mac_cfg_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned SETTLE_CYCLES = 100_000_000,
  parameter logic [7:0]  RESET_MAC     = 8'h40
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] cfg_mac,
  input  logic       tx_busy,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic       cmd_up,
  output logic       cmd_down,
  output logic [7:0] active_mac,
  output logic       mac_updated,
  output logic       cfg_dirty
);

  // One counter width serves both the press counter and the settle counter.
  localparam int unsigned MAX_HR  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_HR > SETTLE_CYCLES) ? MAX_HR : SETTLE_CYCLES;
  localparam int          CW      = $clog2(MAX_ALL + 1);

  // The FIRE cycle counts as the first held cycle, so the first repeat pulse
  // lands HOLD_CYCLES after the initial pulse. HOLD_CYCLES and REPEAT_CYCLES
  // must both be at least 2 to keep an idle cycle between pulses.
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 2);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_MAX  = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FIRE    = 3'd1;
  localparam logic [2:0] ST_HOLD    = 3'd2;
  localparam logic [2:0] ST_REPEAT  = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [1:0] SEL_LEFT  = 2'd0;
  localparam logic [1:0] SEL_RIGHT = 2'd1;
  localparam logic [1:0] SEL_UP    = 2'd2;
  localparam logic [1:0] SEL_DOWN  = 2'd3;

  logic [2:0]    state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] settle_q;
  logic [3:0]    btns;
  logic          any_btn;
  logic          sel_btn;
  logic          fire;
  logic          settle_full;
  logic          commit;

  assign btns    = {btn_down, btn_up, btn_right, btn_left};
  assign any_btn = |btns;
  assign sel_btn = btns[sel_q];

  // Press FSM next-state: picks the button, times hold/repeat, flags pulse cycles.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_btn) begin
          state_d = ST_FIRE;
          fire    = 1'b1;
          if (btn_left)       sel_d = SEL_LEFT;
          else if (btn_right) sel_d = SEL_RIGHT;
          else if (btn_up)    sel_d = SEL_UP;
          else                sel_d = SEL_DOWN;
        end
      end
      ST_FIRE: begin
        if (sel_q == SEL_LEFT || sel_q == SEL_RIGHT) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (!sel_btn) begin
          // Another button still down must be released before a new press.
          state_d = any_btn ? ST_RELEASE : ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_REPEAT;
          fire    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REPEAT: begin
        if (!sel_btn) begin
          state_d = any_btn ? ST_RELEASE : ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          fire  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (!any_btn) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Press FSM state, selected button and hold/repeat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_LEFT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered single-cycle command pulses, visible the cycle after the decision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_left  <= 1'b0;
      cmd_right <= 1'b0;
      cmd_up    <= 1'b0;
      cmd_down  <= 1'b0;
    end else begin
      cmd_left  <= fire && (sel_d == SEL_LEFT);
      cmd_right <= fire && (sel_d == SEL_RIGHT);
      cmd_up    <= fire && (sel_d == SEL_UP);
      cmd_down  <= fire && (sel_d == SEL_DOWN);
    end
  end

  // Settle counter: cleared by every pulse, saturates so a blocked commit stays pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_q <= '0;
    end else if (fire) begin
      settle_q <= '0;
    end else if (settle_q != SETTLE_MAX) begin
      settle_q <= settle_q + CNT_ONE;
    end
  end

  assign settle_full = (settle_q == SETTLE_MAX);
  // A pulse decided this cycle beats the commit; the mac_updated term stops a
  // second commit while cfg_dirty still reflects the pre-commit address.
  assign commit = settle_full && cfg_dirty && !tx_busy && !fire && !mac_updated;

  // Commit path: load the edited address and flag the update for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_mac  <= RESET_MAC;
      mac_updated <= 1'b0;
    end else begin
      mac_updated <= commit;
      if (commit) active_mac <= cfg_mac;
    end
  end

  // Dirty flag: registered compare of the edited and committed addresses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_dirty <= 1'b0;
    end else begin
      cfg_dirty <= (cfg_mac != active_mac);
    end
  end

endmodule
